// File: rtl/can_error_ctrl.sv
// CAN error handling: error-frame sequencing (flag, wait for recessive, delimiter),
// TEC/REC maintenance and fault-confinement state including bus-off recovery.
module can_error_ctrl #(
    parameter int FLAG_BITS   = 6,
    parameter int DELIM_BITS  = 8,
    parameter int BUSOFF_SEQS = 128
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Bit_Tick,
    input  logic       i_Data,
    input  logic [0:3] i_Form_Monitor,
    input  logic       i_Stuff_Error,
    input  logic       i_Crc_Error,
    input  logic       i_Ack_Error,
    input  logic       i_Tx_Mode,
    input  logic       i_Frame_Ok,
    output logic       o_Tx_Drive,
    output logic       o_Tx_Enable,
    output logic       o_Error_Active,
    output logic       o_Frame_Abort,
    output logic [0:8] o_Tec,
    output logic [0:7] o_Rec,
    output logic [0:1] o_Err_State
);

    localparam int CMAX = (DELIM_BITS > FLAG_BITS) ? DELIM_BITS : FLAG_BITS;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = $clog2(BUSOFF_SEQS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FLAG, S_WAIT_REC, S_DELIM, S_BUS_OFF
    } state_t;

    state_t          state_q, state_d;
    logic            err_q, err_d;
    logic            passive_q, passive_d;
    logic            first_q, first_d;
    logic            abort_q, abort_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [8:0]      tec_q, tec_d;
    logic [7:0]      rec_q, rec_d;
    logic [3:0]      run_q, run_d;
    logic [SW-1:0]   seq_q, seq_d;

    logic            err, trig, start_err;
    logic [1:0]      err_st;
    logic [7:0]      rec_inc1, rec_inc8;

    assign err      = (|i_Form_Monitor) | i_Stuff_Error | i_Crc_Error | i_Ack_Error;
    assign trig     = i_Bit_Tick & err & ~err_q;
    assign rec_inc1 = (rec_q == 8'hFF) ? 8'hFF : rec_q + 8'd1;
    assign rec_inc8 = (rec_q > 8'd247) ? 8'hFF : rec_q + 8'd8;

    always_comb begin
        if (tec_q > 9'd255)                           err_st = 2'b10;
        else if (tec_q >= 9'd128 || rec_q >= 8'd128)  err_st = 2'b01;
        else                                          err_st = 2'b00;
    end

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        passive_d = passive_q;
        first_d   = first_q;
        abort_d   = 1'b0;
        cnt_d     = cnt_q;
        tec_d     = tec_q;
        rec_d     = rec_q;
        run_d     = run_q;
        seq_d     = seq_q;
        start_err = 1'b0;

        if (i_Bit_Tick) err_d = err;

        // Bus-off entry is checked every clock and overrides any frame activity.
        if (tec_q > 9'd255 && state_q != S_BUS_OFF) begin
            state_d = S_BUS_OFF;
            cnt_d   = '0;
            first_d = 1'b0;
            run_d   = '0;
            seq_d   = '0;
        end else if (i_Bit_Tick) begin
            case (state_q)
                S_IDLE: begin
                    if (trig) begin
                        start_err = 1'b1;
                    end else if (i_Frame_Ok) begin
                        if (i_Tx_Mode) begin
                            if (tec_q != 9'd0) tec_d = tec_q - 9'd1;
                        end else if (rec_q > 8'd127) begin
                            rec_d = 8'd119;
                        end else if (rec_q != 8'd0) begin
                            rec_d = rec_q - 8'd1;
                        end
                    end
                end
                S_FLAG: begin
                    if (cnt_q == CW'(FLAG_BITS - 1)) begin
                        state_d = S_WAIT_REC;
                        cnt_d   = '0;
                        first_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_WAIT_REC: begin
                    first_d = 1'b0;
                    if (first_q && !i_Tx_Mode && !i_Data) rec_d = rec_inc8;
                    if (i_Data) begin
                        state_d = S_DELIM;
                        cnt_d   = CW'(1);
                    end
                end
                S_DELIM: begin
                    if (i_Data) begin
                        if (cnt_q == CW'(DELIM_BITS - 1)) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        start_err = 1'b1;
                    end
                end
                S_BUS_OFF: begin
                    if (!i_Data) begin
                        run_d = '0;
                    end else if (run_q == 4'd10) begin
                        run_d = '0;
                        if (seq_q == SW'(BUSOFF_SEQS - 1)) begin
                            seq_d   = '0;
                            tec_d   = '0;
                            rec_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            seq_d = seq_q + SW'(1);
                        end
                    end else begin
                        run_d = run_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Flag type is taken from the confinement state before this error is counted.
        if (start_err) begin
            state_d   = S_FLAG;
            cnt_d     = '0;
            passive_d = (err_st != 2'b00);
            abort_d   = 1'b1;
            if (i_Tx_Mode) tec_d = tec_q + 9'd8;
            else           rec_d = rec_inc1;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            err_q     <= 1'b0;
            passive_q <= 1'b0;
            first_q   <= 1'b0;
            abort_q   <= 1'b0;
            cnt_q     <= '0;
            tec_q     <= '0;
            rec_q     <= '0;
            run_q     <= '0;
            seq_q     <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            passive_q <= passive_d;
            first_q   <= first_d;
            abort_q   <= abort_d;
            cnt_q     <= cnt_d;
            tec_q     <= tec_d;
            rec_q     <= rec_d;
            run_q     <= run_d;
            seq_q     <= seq_d;
        end
    end

    assign o_Tx_Drive     = (state_q == S_FLAG) ? passive_q : 1'b1;
    assign o_Tx_Enable    = (state_q != S_BUS_OFF);
    assign o_Error_Active = (state_q == S_FLAG) || (state_q == S_WAIT_REC) || (state_q == S_DELIM);
    assign o_Frame_Abort  = abort_q;
    assign o_Tec          = tec_q;
    assign o_Rec          = rec_q;
    assign o_Err_State    = err_st;

endmodule

// File: tb/tb_can_error_ctrl.sv
// Scoreboard bench for can_error_ctrl: a counting reference model predicts outputs per bit tick,
// a monitor compares the cycle after each tick.
module tb_can_error_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       i_Bit_Tick, i_Data, i_Stuff_Error, i_Crc_Error, i_Ack_Error, i_Tx_Mode, i_Frame_Ok;
    logic [0:3] i_Form_Monitor;
    logic       o_Tx_Drive, o_Tx_Enable, o_Error_Active, o_Frame_Abort;
    logic [0:8] o_Tec;
    logic [0:7] o_Rec;
    logic [0:1] o_Err_State;

    always #5 clk = ~clk;

    can_error_ctrl dut (
        .i_Clock(clk), .i_Reset(rst), .i_Bit_Tick(i_Bit_Tick), .i_Data(i_Data),
        .i_Form_Monitor(i_Form_Monitor), .i_Stuff_Error(i_Stuff_Error), .i_Crc_Error(i_Crc_Error),
        .i_Ack_Error(i_Ack_Error), .i_Tx_Mode(i_Tx_Mode), .i_Frame_Ok(i_Frame_Ok),
        .o_Tx_Drive(o_Tx_Drive), .o_Tx_Enable(o_Tx_Enable), .o_Error_Active(o_Error_Active),
        .o_Frame_Abort(o_Frame_Abort), .o_Tec(o_Tec), .o_Rec(o_Rec), .o_Err_State(o_Err_State)
    );

    typedef struct packed {
        logic       drive;
        logic       en;
        logic       act;
        logic       abort;
        logic [8:0] tec;
        logic [7:0] rec;
        logic [1:0] st;
    } obs_t;

    obs_t dut_obs;
    assign dut_obs = {o_Tx_Drive, o_Tx_Enable, o_Error_Active, o_Frame_Abort, o_Tec, o_Rec, o_Err_State};

    obs_t exp_q[$];
    int   n_tests = 0, n_fail = 0, n_ticks = 0;

    // Reference model: bit counts remaining in each error-frame phase, plain integer counters.
    int m_tec, m_rec, m_flag_left, m_delim, m_run, m_seqs;
    bit m_wait, m_first, m_busoff, m_passive, m_err_prev, m_abort;

    task automatic model_reset();
        m_tec = 0; m_rec = 0; m_flag_left = 0; m_delim = 0; m_run = 0; m_seqs = 0;
        m_wait = 0; m_first = 0; m_busoff = 0; m_passive = 0; m_err_prev = 0; m_abort = 0;
    endtask

    task automatic model_start_err(bit tx);
        m_passive = (m_tec >= 128 || m_rec >= 128);
        if (tx) m_tec += 8;
        else    m_rec = (m_rec + 1 > 255) ? 255 : m_rec + 1;
        m_flag_left = 6; m_delim = 0; m_wait = 0; m_abort = 1;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.drive = m_busoff ? 1'b1 : (m_flag_left > 0 ? m_passive : 1'b1);
        o.en    = !m_busoff;
        o.act   = !m_busoff && (m_flag_left > 0 || m_wait || m_delim > 0);
        o.abort = m_abort;
        o.tec   = 9'(m_tec);
        o.rec   = 8'(m_rec);
        o.st    = (m_tec > 255) ? 2'd2 : ((m_tec >= 128 || m_rec >= 128) ? 2'd1 : 2'd0);
        return o;
    endfunction

    task automatic model_tick(bit data, bit err, bit tx, bit fok);
        bit trig;
        trig = err && !m_err_prev;
        m_err_prev = err;
        m_abort = 0;
        if (!m_busoff && m_tec > 255) begin
            m_busoff = 1; m_flag_left = 0; m_wait = 0; m_delim = 0; m_run = 0; m_seqs = 0;
        end
        if (m_busoff) begin
            if (!data) m_run = 0;
            else if (++m_run == 11) begin
                m_run = 0;
                if (++m_seqs == 128) begin m_seqs = 0; m_tec = 0; m_rec = 0; m_busoff = 0; end
            end
        end else if (m_flag_left > 0) begin
            m_flag_left--;
            if (m_flag_left == 0) begin m_wait = 1; m_first = 1; end
        end else if (m_wait) begin
            if (m_first && !tx && !data) m_rec = (m_rec + 8 > 255) ? 255 : m_rec + 8;
            m_first = 0;
            if (data) begin m_wait = 0; m_delim = 1; end
        end else if (m_delim > 0) begin
            if (data) begin m_delim++; if (m_delim == 8) m_delim = 0; end
            else model_start_err(tx);
        end else if (trig) begin
            model_start_err(tx);
        end else if (fok) begin
            if (tx) begin if (m_tec > 0) m_tec--; end
            else if (m_rec > 127) m_rec = 119;
            else if (m_rec > 0) m_rec--;
        end
        exp_q.push_back(model_obs());
    endtask

    task automatic check(string name, obs_t got, obs_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s tick %0d: got drive=%0b en=%0b act=%0b abort=%0b tec=%0d rec=%0d st=%0d, want drive=%0b en=%0b act=%0b abort=%0b tec=%0d rec=%0d st=%0d",
                     name, n_ticks, got.drive, got.en, got.act, got.abort, got.tec, got.rec, got.st,
                     want.drive, want.en, want.act, want.abort, want.tec, want.rec, want.st);
        end
    endtask

    // Monitor: compares the cycle after each tick, and checks the abort pulse is gone one cycle later.
    logic tick_d, tick_d2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin tick_d <= 1'b0; tick_d2 <= 1'b0; end
        else     begin tick_d <= i_Bit_Tick; tick_d2 <= tick_d; end
    end

    always @(negedge clk) begin
        if (tick_d) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL scoreboard_empty tick %0d: got an output with no expected entry", n_ticks);
            end else begin
                check("tick", dut_obs, exp_q.pop_front());
            end
        end
        if (tick_d2) begin
            n_tests++;
            if (o_Frame_Abort !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_width tick %0d: got abort=%0b want 0", n_ticks, o_Frame_Abort);
            end
        end
    end

    // One bit time: tick pulse for one cycle, then two idle cycles.
    task automatic bt(bit data, bit [6:0] ev, bit tx, bit fok);
        i_Data = data; i_Form_Monitor = ev[3:0]; i_Stuff_Error = ev[4];
        i_Crc_Error = ev[5]; i_Ack_Error = ev[6]; i_Tx_Mode = tx; i_Frame_Ok = fok;
        i_Bit_Tick = 1'b1;
        n_ticks++;
        model_tick(data, |ev, tx, fok);
        @(posedge clk); #1;
        i_Bit_Tick = 1'b0; i_Frame_Ok = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic err_frame(bit tx, int n_dom, int src);
        bit [6:0] ev;
        ev = 7'(1) << (src % 7);
        bt(1'b1, ev, tx, 1'b0);
        for (int i = 0; i < 6; i++) bt(1'b0, 7'd0, tx, 1'b0);
        for (int i = 0; i < n_dom; i++) bt(1'b0, 7'd0, tx, 1'b0);
        for (int i = 0; i < 9; i++) bt(1'b1, 7'd0, tx, 1'b0);
    endtask

    task automatic do_reset();
        i_Bit_Tick = 1'b0; i_Frame_Ok = 1'b0; i_Data = 1'b1; i_Form_Monitor = 4'd0;
        i_Stuff_Error = 1'b0; i_Crc_Error = 1'b0; i_Ack_Error = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    obs_t rst_obs;

    initial begin
        i_Tx_Mode = 1'b0;
        rst_obs = {1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 8'd0, 2'd0};
        do_reset();
        check("reset_state", dut_obs, rst_obs);

        // Receiver: stuff error at tick 10, held through part of the flag (no retrigger).
        for (int i = 0; i < 9; i++) bt(1'b1, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) bt(i == 0, 7'b0010000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) bt(1'b0, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) bt(1'b1, 7'd0, 1'b0, 1'b0);

        // Transmitter: 17 errors, the 17th gives a passive flag.
        do_reset();
        for (int i = 0; i < 17; i++) err_frame(1'b1, 0, i % 4);

        // Receiver: dominant for 3 ticks after the flag.
        do_reset();
        err_frame(1'b0, 3, 5);

        // Dominant on delimiter tick 4 restarts the flag.
        bt(1'b1, 7'b1000000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) bt(1'b0, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) bt(1'b1, 7'd0, 1'b0, 1'b0);
        bt(1'b0, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) bt(1'b0, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) bt(1'b1, 7'd0, 1'b0, 1'b0);

        // Bus-off via 32 transmitter errors, then recovery with one dominant mid-run.
        do_reset();
        for (int i = 0; i < 32; i++) err_frame(1'b1, 0, i);
        for (int i = 0; i < 5; i++) bt(1'b1, 7'd0, 1'b1, 1'b0);
        bt(1'b0, 7'b0000001, 1'b1, 1'b1);
        for (int i = 0; i < 2000 && m_busoff; i++) bt(1'b1, 7'd0, 1'b1, 1'b0);
        n_tests++;
        if (m_busoff) begin
            n_fail++;
            $display("FAIL busoff_recovery tick %0d: got still bus-off want recovered", n_ticks);
        end
        for (int i = 0; i < 3; i++) bt(1'b1, 7'd0, 1'b1, 1'b0);

        // REC=130 then frame ok -> 119; REC=130 with trigger and frame ok -> 131.
        do_reset();
        for (int i = 0; i < 14; i++) err_frame(1'b0, 1, i);
        for (int i = 0; i < 4; i++) err_frame(1'b0, 0, i);
        bt(1'b1, 7'd0, 1'b0, 1'b1);
        err_frame(1'b0, 1, 2);
        for (int i = 0; i < 2; i++) err_frame(1'b0, 0, i);
        bt(1'b1, 7'b0000010, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) bt(1'b0, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) bt(1'b1, 7'd0, 1'b0, 1'b0);

        // Reset asserted mid-flag, away from a clock edge.
        bt(1'b1, 7'b0000100, 1'b1, 1'b0);
        bt(1'b0, 7'd0, 1'b1, 1'b0);
        bt(1'b0, 7'd0, 1'b1, 1'b0);
        i_Form_Monitor = 4'd0; i_Stuff_Error = 1'b0; i_Crc_Error = 1'b0; i_Ack_Error = 1'b0;
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("reset_in_flag", dut_obs, rst_obs);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit [6:0] ev;
            ev = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
            bt(($urandom_range(0, 7) != 0), ev, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/can_error_ctrl.md
# can_error_ctrl

CAN error-handling controller that sequences the bus response to detected protocol errors. It merges the form-monitor vector with stuff, CRC and ACK error flags and drives an error frame: an error flag, then a wait for a recessive bus level, then the error delimiter. It also maintains the transmit and receive error counters (TEC/REC) and the fault-confinement state (error-active, error-passive, bus-off). It sits between the frame decoder/error monitors and the bit-level TX driver, one instance per node.

## Interface
- FLAG_BITS, 6, length of the error flag in bits
- DELIM_BITS, 8, length of the error delimiter in bits, counting the first recessive bit
- BUSOFF_SEQS, 128, number of 11-recessive-bit sequences required for bus-off recovery

- i_Clock  in  1  system clock
- i_Reset  in  1  asynchronous, active-high reset
- i_Bit_Tick  in  1  one-cycle pulse at the bit sample point; all bus logic advances only on ticks
- i_Data  in  1  sampled bus level, valid when i_Bit_Tick=1 (1 = recessive)
- i_Form_Monitor  in  [0:3]  form-error flags from the form monitor
- i_Stuff_Error, i_Crc_Error, i_Ack_Error  in  1 each  error flags
- i_Tx_Mode  in  1  node is the transmitter of the current frame
- i_Frame_Ok  in  1  pulse, coincident with a tick, marking successful end of frame
- o_Tx_Drive  out  1  bit level to drive (0 = dominant)
- o_Tx_Enable  out  1  node may transmit (0 in bus-off)
- o_Error_Active  out  1  error frame in progress
- o_Frame_Abort  out  1  one-cycle pulse when an error frame starts
- o_Tec  out  [0:8]  transmit error counter
- o_Rec  out  [0:7]  receive error counter
- o_Err_State  out  [0:1]  00 active, 01 passive, 10 bus-off

## Operation
- Aggregate error: err = OR(i_Form_Monitor) | i_Stuff_Error | i_Crc_Error | i_Ack_Error. It is registered on each tick. A trigger is a rising edge of err (0→1) between consecutive ticks, so held monitor flags do not retrigger.
- States: IDLE, FLAG, WAIT_REC, DELIM, BUS_OFF.
- IDLE
  - Trigger on a tick → FLAG.
  - The flag type latches from o_Err_State before the counter update: active flag = dominant, passive flag = recessive.
  - Counters update: i_Tx_Mode=1 → TEC += 8; otherwise REC += 1, saturating at 255.
  - o_Frame_Abort pulses.
- FLAG
  - o_Tx_Drive = 0 for an active flag, 1 for a passive flag.
  - After FLAG_BITS ticks → WAIT_REC.
- WAIT_REC
  - o_Tx_Drive = 1.
  - On the first tick after the flag, if i_Tx_Mode=0 and i_Data=0 → REC += 8, saturating.
  - On a tick with i_Data=1 → DELIM, with the delimiter count set to 1.
- DELIM
  - o_Tx_Drive = 1.
  - Tick with i_Data=1: increment the count; at DELIM_BITS → IDLE.
  - Tick with i_Data=0: delimiter form error. Restart FLAG with the same counter rules as a fresh trigger, and pulse o_Frame_Abort.
- i_Frame_Ok on a tick in IDLE with no trigger:
  - i_Tx_Mode=1: TEC -= 1 if TEC > 0.
  - i_Tx_Mode=0: REC -= 1 if 1 ≤ REC ≤ 127; REC = 119 if REC > 127.
  - i_Frame_Ok is ignored outside IDLE.
- o_Err_State is combinational from the registered counters:
  - TEC > 255 → 10.
  - Else TEC ≥ 128 or REC ≥ 128 → 01.
  - Else 00.
- Entering bus-off: any state → BUS_OFF on the clock after TEC exceeds 255. This preempts the error frame and forces o_Tx_Drive=1.
- BUS_OFF
  - o_Tx_Enable = 0. Triggers and i_Frame_Ok are ignored.
  - A run counter counts consecutive recessive ticks; a dominant tick clears it.
  - On reaching 11, the run counter clears and the sequence counter increments.
  - At BUSOFF_SEQS sequences: TEC = 0, REC = 0, o_Tx_Enable = 1 → IDLE.
- o_Error_Active = 1 in FLAG, WAIT_REC and DELIM.
- Triggers arriving in FLAG or WAIT_REC are ignored, but the edge register still tracks err.

## Timing
- Reset values: o_Tx_Drive=1, o_Tx_Enable=1, o_Error_Active=0, o_Frame_Abort=0, o_Tec=0, o_Rec=0, o_Err_State=00, state IDLE. All internal counters are 0.
- Asserting reset mid-frame returns everything to these values immediately, without waiting for a clock.
- All transitions and counter updates occur on the i_Clock edge where i_Bit_Tick=1. Outputs change in the cycle after that edge.
- Error flag latency: a trigger on tick N drives the flag level from the cycle after N through tick N+FLAG_BITS. o_Tx_Drive returns to 1 after tick N+FLAG_BITS.
- o_Frame_Abort is high for exactly one cycle following the trigger tick.
- Counter changes and o_Err_State are visible in the same cycle.
- Simultaneous trigger and i_Frame_Ok: the error wins and the decrement is skipped.
- TEC cannot overflow 9 bits: the maximum value is 255+8 = 263, and bus-off blocks further increments.

## Test plan
- Receiver in IDLE, i_Stuff_Error rises at tick 10 → o_Tx_Drive=0 for ticks 11–16, REC=1, one o_Frame_Abort pulse. With the bus recessive afterwards, o_Error_Active falls after 8 delimiter ticks.
- Transmitter, 16 consecutive form errors, each followed by a full error frame → TEC=128, o_Err_State=01. The 17th error produces a recessive (passive) flag.
- Receiver after a flag sees the bus dominant for 3 ticks, then recessive → REC += 1 + 8, and DELIM starts on the first recessive tick.
- Dominant bit on delimiter tick 4 → a new flag starts on the next tick, REC increments again, o_Frame_Abort pulses again.
- Force TEC=256 via 32 transmitter errors → o_Err_State=10, o_Tx_Enable=0. After 128×11 recessive ticks, with a dominant tick mid-run resetting the run counter → TEC=0, REC=0, state 00.
- REC=130 with i_Frame_Ok as receiver → REC=119. The same tick with a trigger → REC=131, i_Frame_Ok ignored. Reset asserted during FLAG → o_Tx_Drive=1 immediately.
